div_seq: RTL and testbench

- Parametrised multi-cycle integer divider for the MIPS execution stage. Generalises the fixed 32-bit unsigned divider.
- Configurable operand width; per-operation signed/unsigned mode.
- Explicit divide-by-zero detection; one-cycle done pulse.
- Results are held stable for the HI/LO write-back logic until the next operation starts.

---
 rtl/div_seq.sv | 83 ++++++++
 tb/tb_div_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle signed/unsigned non-restoring integer divider with divide-by-zero detection
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] a, d;
  logic             sign_q, sign_r, zero;
  logic [WIDTH-1:0] mag_dvd, mag_dvs, r_mag;
  logic [WIDTH:0]   p_sh, p_nxt;
  always_comb begin
    mag_dvd = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_dvs = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
    p_sh    = {p[WIDTH-1:0], a[WIDTH-1]};
    p_nxt   = p[WIDTH] ? p_sh + {1'b0, d} : p_sh - {1'b0, d};
    r_mag   = p[WIDTH-1:0] + (p[WIDTH] ? d : '0);
  end
  // a holds the dividend magnitude shifting out while quotient bits shift in;
  // on the zero path it keeps the raw dividend so it can be returned unmodified
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      p        <= '0;
      a        <= '0;
      d        <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      zero     <= 1'b0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sign_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          sign_r   <= is_signed & dividend[WIDTH-1];
          zero     <= divisor == '0;
          a        <= divisor == '0 ? dividend : mag_dvd;
          d        <= mag_dvs;
          p        <= '0;
          cnt      <= '0;
          busy     <= 1'b1;
          div_zero <= 1'b0;
          state    <= divisor == '0 ? FIX : RUN;
        end
        RUN: begin
          p     <= p_nxt;
          a     <= {a[WIDTH-2:0], ~p_nxt[WIDTH]};
          cnt   <= cnt + 1'b1;
          state <= cnt == CW'(WIDTH-1) ? FIX : RUN;
        end
        FIX: begin
          q        <= zero ? '1 : (sign_q ? -a : a);
          r        <= zero ? a : (sign_r ? -r_mag : r_mag);
          div_zero <= zero;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed checks of div_seq at WIDTH=32 and WIDTH=8
module tb_div_seq;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  logic        st32 = 1'b0, sg32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, q32, r32;
  logic        busy32, done32, dz32;
  logic        st8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, q8, r8;
  logic        busy8, done8, dz8;
  div_seq #(.WIDTH(32)) u32 (
    .clock(clock), .reset(reset), .start(st32), .is_signed(sg32),
    .dividend(a32), .divisor(b32), .q(q32), .r(r32),
    .busy(busy32), .done(done32), .div_zero(dz32)
  );
  div_seq #(.WIDTH(8)) u8 (
    .clock(clock), .reset(reset), .start(st8), .is_signed(sg8),
    .dividend(a8), .divisor(b8), .q(q8), .r(r8),
    .busy(busy8), .done(done8), .div_zero(dz8)
  );
  int n_cmp = 0, n_err = 0;
  int lat;
  logic dz_acc;
  logic [31:0] q_acc;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask
  task automatic op(input bit n8, input bit s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    if (n8) begin st8 = 1'b1; sg8 = s; a8 = x[7:0]; b8 = y[7:0]; end
    else begin st32 = 1'b1; sg32 = s; a32 = x; b32 = y; end
    @(posedge clock);
    #1;
    st8 = 1'b0;
    st32 = 1'b0;
    chk("busy_at_accept", n8 ? busy8 : busy32, 1);
    dz_acc = n8 ? dz8 : dz32;
    q_acc = n8 ? {24'h0, q8} : q32;
    lat = 0;
    while (!(n8 ? done8 : done32) && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask
  task automatic pulse_end(input bit n8);
    @(posedge clock);
    #1;
    chk("done_one_cycle", n8 ? done8 : done32, 0);
    chk("busy_after_done", n8 ? busy8 : busy32, 0);
  endtask
  initial begin
    int seen;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_q", q32, 0);
    chk("rst_r", r32, 0);
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_dz", dz32, 0);
    chk("rst_q8", q8, 0);
    @(negedge clock);
    reset = 1'b0;
    op(0, 0, 32'd100, 32'd7);
    chk("u100_7_lat", lat, 33);
    chk("u100_7_q", q32, 14);
    chk("u100_7_r", r32, 2);
    chk("u100_7_dz", dz32, 0);
    pulse_end(0);
    repeat (3) @(posedge clock);
    #1;
    chk("hold_q", q32, 14);
    op(0, 1, 32'hFFFFFFF9, 32'd2);
    chk("sm7_2_q", q32, 32'hFFFFFFFD);
    chk("sm7_2_r", r32, 32'hFFFFFFFF);
    op(0, 1, 32'd7, 32'hFFFFFFFE);
    chk("s7_m2_q", q32, 32'hFFFFFFFD);
    chk("s7_m2_r", r32, 32'h1);
    op(0, 1, 32'h80000000, 32'hFFFFFFFF);
    chk("smin_m1_q", q32, 32'h80000000);
    chk("smin_m1_r", r32, 0);
    chk("smin_m1_dz", dz32, 0);
    op(0, 0, 32'h80000000, 32'hFFFFFFFF);
    chk("umin_m1_q", q32, 0);
    chk("umin_m1_r", r32, 32'h80000000);
    op(0, 1, 32'h12345678, 32'h0);
    chk("zero_lat", lat, 1);
    chk("zero_q", q32, 32'hFFFFFFFF);
    chk("zero_r", r32, 32'h12345678);
    chk("zero_dz", dz32, 1);
    pulse_end(0);
    chk("zero_dz_held", dz32, 1);
    op(0, 0, 32'd100, 32'd7);
    chk("next_clears_dz", dz_acc, 0);
    chk("q_held_in_run", q_acc, 32'hFFFFFFFF);
    chk("after_zero_q", q32, 14);
    // restart attempt mid-operation must not disturb the running division
    @(negedge clock);
    st32 = 1'b1; sg32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
    @(posedge clock);
    #1;
    st32 = 1'b0;
    lat = 0;
    while (!done32 && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      if (lat == 9) begin st32 = 1'b1; a32 = 32'd1000; b32 = 32'd3; end
      if (lat == 10) st32 = 1'b0;
    end
    chk("ign_lat", lat, 33);
    chk("ign_q", q32, 14);
    chk("ign_r", r32, 2);
    pulse_end(0);
    @(negedge clock);
    st32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
    @(posedge clock);
    #1;
    st32 = 1'b0;
    repeat (15) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy32, 0);
    chk("midrst_q", q32, 0);
    chk("midrst_r", r32, 0);
    chk("midrst_done", done32, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done32) seen = 1;
    end
    chk("midrst_no_done", seen, 0);
    op(1, 0, 32'd255, 32'd1);
    chk("w8_255_1_lat", lat, 9);
    chk("w8_255_1_q", q8, 8'hFF);
    chk("w8_255_1_r", r8, 0);
    pulse_end(1);
    op(1, 1, 32'h81, 32'h03);
    chk("w8_s81_3_q", q8, 8'hD6);
    chk("w8_s81_3_r", r8, 8'hFF);
    op(1, 1, 32'h80, 32'hFF);
    chk("w8_min_m1_q", q8, 8'h80);
    chk("w8_min_m1_r", r8, 0);
    op(1, 0, 32'hA5, 32'h0);
    chk("w8_zero_lat", lat, 1);
    chk("w8_zero_q", q8, 8'hFF);
    chk("w8_zero_r", r8, 8'hA5);
    chk("w8_zero_dz", dz8, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
